// File: rtl/mb_io_arbiter.sv
// mb_io_arbiter: two-master round-robin arbiter for the MicroBlaze IO bus.
// Each master gets a single-entry holding register. One transaction at a time
// is serialised onto the shared slave port through IDLE -> ISSUE -> WAIT.
// Optional build macro: MB_IO_ARB_TIMEOUT_EN adds a WAIT-state watchdog that
// forces completion after TIMEOUT_CYCLES (reads then return 32'hDEAD_BEEF).
module mb_io_arbiter #(
    parameter int ADDR_W         = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              M0_IO_Addr_Strobe,
    input  logic              M0_IO_Read_Strobe,
    input  logic              M0_IO_Write_Strobe,
    input  logic [ADDR_W-1:0] M0_IO_Address,
    input  logic [3:0]        M0_IO_Byte_Enable,
    input  logic [31:0]       M0_IO_Write_Data,
    output logic [31:0]       M0_IO_Read_Data,
    output logic              M0_IO_Ready,
    input  logic              M1_IO_Addr_Strobe,
    input  logic              M1_IO_Read_Strobe,
    input  logic              M1_IO_Write_Strobe,
    input  logic [ADDR_W-1:0] M1_IO_Address,
    input  logic [3:0]        M1_IO_Byte_Enable,
    input  logic [31:0]       M1_IO_Write_Data,
    output logic [31:0]       M1_IO_Read_Data,
    output logic              M1_IO_Ready,
    output logic              S_IO_Addr_Strobe,
    output logic              S_IO_Read_Strobe,
    output logic              S_IO_Write_Strobe,
    output logic [ADDR_W-1:0] S_IO_Address,
    output logic [3:0]        S_IO_Byte_Enable,
    output logic [31:0]       S_IO_Write_Data,
    input  logic [31:0]       S_IO_Read_Data,
    input  logic              S_IO_Ready,
    output logic              arb_busy,
    output logic              arb_grant,
    output logic              arb_timeout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state, state_nxt;

    // Master-side buses gathered into per-master arrays (index = master)
    logic [1:0]                    m_as, m_rd, m_wr;
    logic [1:0][ADDR_W-1:0]        m_addr;
    logic [1:0][3:0]               m_be;
    logic [1:0][31:0]              m_wdata;
    logic [1:0]                    m_rdy;
    logic [1:0][31:0]              m_rdata;

    // Holding registers
    logic [1:0]                    pend;
    logic [1:0]                    h_rnw;
    logic [1:0][ADDR_W-1:0]        h_addr;
    logic [1:0][3:0]               h_be;
    logic [1:0][31:0]              h_wdata;

    logic last_grant;
    logic gnt_sel;
    logic tmo_hit;
    logic tmo_fire;
    logic done;

    assign m_as    = {M1_IO_Addr_Strobe,  M0_IO_Addr_Strobe};
    assign m_rd    = {M1_IO_Read_Strobe,  M0_IO_Read_Strobe};
    assign m_wr    = {M1_IO_Write_Strobe, M0_IO_Write_Strobe};
    assign m_addr  = {M1_IO_Address,      M0_IO_Address};
    assign m_be    = {M1_IO_Byte_Enable,  M0_IO_Byte_Enable};
    assign m_wdata = {M1_IO_Write_Data,   M0_IO_Write_Data};

    assign M0_IO_Ready     = m_rdy[0];
    assign M1_IO_Ready     = m_rdy[1];
    assign M0_IO_Read_Data = m_rdata[0];
    assign M1_IO_Read_Data = m_rdata[1];

    assign arb_busy = (state != IDLE);
    assign done     = (state == WAIT) && (S_IO_Ready || tmo_hit);
    assign tmo_fire = tmo_hit && !S_IO_Ready;

`ifdef MB_IO_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] tmo_cnt;

    assign tmo_hit = (state == WAIT) && (tmo_cnt == TMO_LIM);

    // Watchdog: count WAIT cycles; the timeout pulse lines up with Mx_IO_Ready
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt     <= '0;
            arb_timeout <= 1'b0;
        end else begin
            arb_timeout <= tmo_fire;
            if (state == ISSUE)
                tmo_cnt <= '0;
            else if (state == WAIT && !tmo_hit)
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign arb_timeout = 1'b0;
`endif

    // Round-robin pick: a lone requester wins, a tie goes to the other master
    always_comb begin
        gnt_sel = pend[1];
        if (pend == 2'b11)
            gnt_sel = ~last_grant;
    end

    // Per-master capture: well-formed strobe into an empty slot, freed on completion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend    <= '0;
            h_rnw   <= '0;
            h_addr  <= '0;
            h_be    <= '0;
            h_wdata <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (done && arb_grant == 1'(i)) begin
                    pend[i] <= 1'b0;
                end else if (m_as[i] && (m_rd[i] ^ m_wr[i]) && !pend[i]) begin
                    pend[i]    <= 1'b1;
                    h_rnw[i]   <= m_rd[i];
                    h_addr[i]  <= m_addr[i];
                    h_be[i]    <= m_be[i];
                    h_wdata[i] <= m_wdata[i];
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state: IDLE grants, ISSUE lasts one cycle, WAIT holds until done
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|pend) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered slave request on grant, registered master response on completion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            S_IO_Addr_Strobe  <= 1'b0;
            S_IO_Read_Strobe  <= 1'b0;
            S_IO_Write_Strobe <= 1'b0;
            S_IO_Address      <= '0;
            S_IO_Byte_Enable  <= '0;
            S_IO_Write_Data   <= '0;
            arb_grant         <= 1'b0;
            last_grant        <= 1'b1;
            m_rdy             <= '0;
            m_rdata           <= '0;
        end else begin
            S_IO_Addr_Strobe  <= 1'b0;
            S_IO_Read_Strobe  <= 1'b0;
            S_IO_Write_Strobe <= 1'b0;
            m_rdy             <= '0;
            if (state == IDLE && |pend) begin
                arb_grant         <= gnt_sel;
                S_IO_Addr_Strobe  <= 1'b1;
                S_IO_Read_Strobe  <= h_rnw[gnt_sel];
                S_IO_Write_Strobe <= ~h_rnw[gnt_sel];
                S_IO_Address      <= h_addr[gnt_sel];
                S_IO_Byte_Enable  <= h_be[gnt_sel];
                S_IO_Write_Data   <= h_wdata[gnt_sel];
            end
            if (done) begin
                m_rdy[arb_grant] <= 1'b1;
                last_grant       <= arb_grant;
                if (h_rnw[arb_grant])
                    m_rdata[arb_grant] <= tmo_fire ? 32'hDEAD_BEEF : S_IO_Read_Data;
            end
        end
    end

endmodule

// File: tb/tb_mb_io_arbiter.sv
// Directed bench for mb_io_arbiter with a one-cycle-latency slave model.
module tb_mb_io_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        M0_IO_Addr_Strobe = 0, M0_IO_Read_Strobe = 0, M0_IO_Write_Strobe = 0;
    logic [2:0]  M0_IO_Address = 0;
    logic [3:0]  M0_IO_Byte_Enable = 0;
    logic [31:0] M0_IO_Write_Data = 0;
    logic [31:0] M0_IO_Read_Data;
    logic        M0_IO_Ready;
    logic        M1_IO_Addr_Strobe = 0, M1_IO_Read_Strobe = 0, M1_IO_Write_Strobe = 0;
    logic [2:0]  M1_IO_Address = 0;
    logic [3:0]  M1_IO_Byte_Enable = 0;
    logic [31:0] M1_IO_Write_Data = 0;
    logic [31:0] M1_IO_Read_Data;
    logic        M1_IO_Ready;
    logic        S_IO_Addr_Strobe, S_IO_Read_Strobe, S_IO_Write_Strobe;
    logic [2:0]  S_IO_Address;
    logic [3:0]  S_IO_Byte_Enable;
    logic [31:0] S_IO_Write_Data;
    logic [31:0] S_IO_Read_Data = 0;
    logic        S_IO_Ready = 0;
    logic        arb_busy, arb_grant, arb_timeout;

    int n_assert = 0;
    int n_fail   = 0;

    // slave model / monitor state
    logic        slave_en = 1'b1;
    logic        late_rdy = 1'b0;
    logic        strobe_seen = 1'b0;
    logic [31:0] rd_next = 0;
    int          s_cnt = 0, r0_cnt = 0, r1_cnt = 0;
    logic [2:0]  s_last_addr = 0;

    logic [110:0] all_out;
    assign all_out = {M0_IO_Read_Data, M1_IO_Read_Data, M0_IO_Ready, M1_IO_Ready,
                      S_IO_Addr_Strobe, S_IO_Read_Strobe, S_IO_Write_Strobe, S_IO_Address,
                      S_IO_Byte_Enable, S_IO_Write_Data, arb_busy, arb_grant, arb_timeout};

    mb_io_arbiter #(.ADDR_W(3), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .M0_IO_Addr_Strobe(M0_IO_Addr_Strobe), .M0_IO_Read_Strobe(M0_IO_Read_Strobe),
        .M0_IO_Write_Strobe(M0_IO_Write_Strobe), .M0_IO_Address(M0_IO_Address),
        .M0_IO_Byte_Enable(M0_IO_Byte_Enable), .M0_IO_Write_Data(M0_IO_Write_Data),
        .M0_IO_Read_Data(M0_IO_Read_Data), .M0_IO_Ready(M0_IO_Ready),
        .M1_IO_Addr_Strobe(M1_IO_Addr_Strobe), .M1_IO_Read_Strobe(M1_IO_Read_Strobe),
        .M1_IO_Write_Strobe(M1_IO_Write_Strobe), .M1_IO_Address(M1_IO_Address),
        .M1_IO_Byte_Enable(M1_IO_Byte_Enable), .M1_IO_Write_Data(M1_IO_Write_Data),
        .M1_IO_Read_Data(M1_IO_Read_Data), .M1_IO_Ready(M1_IO_Ready),
        .S_IO_Addr_Strobe(S_IO_Addr_Strobe), .S_IO_Read_Strobe(S_IO_Read_Strobe),
        .S_IO_Write_Strobe(S_IO_Write_Strobe), .S_IO_Address(S_IO_Address),
        .S_IO_Byte_Enable(S_IO_Byte_Enable), .S_IO_Write_Data(S_IO_Write_Data),
        .S_IO_Read_Data(S_IO_Read_Data), .S_IO_Ready(S_IO_Ready),
        .arb_busy(arb_busy), .arb_grant(arb_grant), .arb_timeout(arb_timeout)
    );

    always #5 clk = ~clk;

    // Monitor at the falling edge: log slave strobes and master readies
    always @(negedge clk) begin
        strobe_seen = S_IO_Addr_Strobe && slave_en;
        if (S_IO_Addr_Strobe) begin
            s_cnt++;
            s_last_addr = S_IO_Address;
        end
        if (M0_IO_Ready) r0_cnt++;
        if (M1_IO_Ready) r1_cnt++;
        if (strobe_seen)
            rd_next = (S_IO_Address == 3'd1) ? 32'h1234_5678 : (32'hA5A5_0000 | 32'(S_IO_Address));
    end

    // Slave answers in the cycle after its strobe
    always @(posedge clk) begin
        #2;
        S_IO_Ready     = strobe_seen | late_rdy;
        S_IO_Read_Data = rd_next;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_m();
        M0_IO_Addr_Strobe = 0; M0_IO_Read_Strobe = 0; M0_IO_Write_Strobe = 0;
        M1_IO_Addr_Strobe = 0; M1_IO_Read_Strobe = 0; M1_IO_Write_Strobe = 0;
    endtask

    task automatic m_req(input int m, input bit rd, input logic [2:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        if (m == 0) begin
            M0_IO_Addr_Strobe = 1; M0_IO_Read_Strobe = rd; M0_IO_Write_Strobe = !rd;
            M0_IO_Address = a; M0_IO_Write_Data = wd; M0_IO_Byte_Enable = be;
        end else begin
            M1_IO_Addr_Strobe = 1; M1_IO_Read_Strobe = rd; M1_IO_Write_Strobe = !rd;
            M1_IO_Address = a; M1_IO_Write_Data = wd; M1_IO_Byte_Enable = be;
        end
    endtask

    task automatic do_reset();
        clr_m();
        reset_n = 0;
        step();
        step();
        reset_n = 1;
    endtask

    initial begin
        int c0, c1, r0, r1, g, n, sb, rb0, rb1;

        // ---- reset: random strobes while held in reset
        reset_n = 0;
        for (int i = 0; i < 4; i++) begin
            M0_IO_Addr_Strobe = 1'($urandom); M0_IO_Read_Strobe = 1'($urandom);
            M0_IO_Write_Strobe = 1'($urandom); M1_IO_Addr_Strobe = 1'($urandom);
            M1_IO_Read_Strobe = 1'($urandom); M1_IO_Write_Strobe = 1'($urandom);
            step();
            chk($sformatf("reset_outs%0d", i), 128'(all_out), 128'd0);
        end
        clr_m();
        reset_n = 1;
        step();

        // ---- uncontended M0 read of addr 1
        m_req(0, 1, 3'd1, 32'h0, 4'hF);           // cycle N
        step(); clr_m();                           // N+1
        chk("rd_n1_sstb", S_IO_Addr_Strobe, 1'b0);
        step();                                    // N+2
        chk("rd_n2_strobes", {S_IO_Addr_Strobe, S_IO_Read_Strobe, S_IO_Write_Strobe}, 3'b110);
        chk("rd_n2_addr", S_IO_Address, 3'd1);
        chk("rd_n2_busy_gnt", {arb_busy, arb_grant}, 2'b10);
        step();                                    // N+3
        chk("rd_n3_rdy", {S_IO_Addr_Strobe, M0_IO_Ready}, 2'b00);
        step();                                    // N+4
        chk("rd_n4_rdy", {M0_IO_Ready, M1_IO_Ready}, 2'b10);
        chk("rd_n4_data", M0_IO_Read_Data, 32'h1234_5678);
        step();
        chk("rd_n5_idle", {M0_IO_Ready, arb_busy}, 2'b00);

        // ---- contention from reset: M0 wins the tie
        do_reset();
        rb0 = r0_cnt; rb1 = r1_cnt;
        m_req(0, 0, 3'd0, 32'h0000_0011, 4'hF);
        m_req(1, 0, 3'd2, 32'h0000_0022, 4'h3);   // N
        step(); clr_m();                           // N+1
        step();                                    // N+2
        chk("ct_m0_issue", {S_IO_Write_Strobe, arb_grant, S_IO_Address, S_IO_Byte_Enable}, {1'b1, 1'b0, 3'd0, 4'hF});
        chk("ct_m0_wdata", S_IO_Write_Data, 32'h11);
        step(); step();                            // N+4
        chk("ct_m0_rdy", {M0_IO_Ready, M1_IO_Ready, S_IO_Addr_Strobe}, 3'b100);
        chk("ct_m0_rdata_hold", M0_IO_Read_Data, 32'h0);
        step();                                    // N+5
        chk("ct_m1_issue", {S_IO_Write_Strobe, arb_grant, S_IO_Address, S_IO_Byte_Enable}, {1'b1, 1'b1, 3'd2, 4'h3});
        chk("ct_m1_wdata", S_IO_Write_Data, 32'h22);
        step(); step();                            // N+7
        chk("ct_m1_rdy", {M0_IO_Ready, M1_IO_Ready}, 2'b01);
        step(); step();
        chk("ct_rdy_counts", {8'(r0_cnt - rb0), 8'(r1_cnt - rb1)}, {8'd1, 8'd1});

        // ---- fairness: both re-request on every Ready, 20 transactions
        c0 = 0; c1 = 0; g = 0;
        m_req(0, 1, 3'd3, 32'h0, 4'hF);
        m_req(1, 1, 3'd4, 32'h0, 4'hF);
        r0 = 1; r1 = 1;
        step(); clr_m();
        for (int cyc = 0; cyc < 400 && (c0 + c1) < 20; cyc++) begin
            if (S_IO_Addr_Strobe) begin
                chk($sformatf("fair_gnt%0d", g), {arb_grant, S_IO_Address},
                    (g % 2) ? {1'b1, 3'd4} : {1'b0, 3'd3});
                g++;
            end
            clr_m();
            if (M0_IO_Ready) begin
                c0++;
                if (r0 < 10) begin m_req(0, 1, 3'd3, 32'h0, 4'hF); r0++; end
            end
            if (M1_IO_Ready) begin
                c1++;
                if (r1 < 10) begin m_req(1, 1, 3'd4, 32'h0, 4'hF); r1++; end
            end
            step();
        end
        clr_m();
        chk("fair_counts", {8'(c0), 8'(c1), 8'(g)}, {8'd10, 8'd10, 8'd20});
        chk("fair_rdata", {M0_IO_Read_Data, M1_IO_Read_Data}, {32'hA5A5_0003, 32'hA5A5_0004});
        step(); step(); step();

        // ---- protocol: second strobe while pending, malformed strobe
        sb = s_cnt; rb0 = r0_cnt; rb1 = r1_cnt;
        m_req(1, 1, 3'd5, 32'h0, 4'hF);           // N
        step();                                    // N+1
        m_req(1, 0, 3'd6, 32'h0, 4'hF);           // dropped: pend_1 set
        m_req(0, 1, 3'd7, 32'h0, 4'hF);
        M0_IO_Write_Strobe = 1;                    // read+write: dropped
        step(); clr_m();
        for (int i = 0; i < 8; i++) step();
        chk("proto_s_cnt", {8'(s_cnt - sb), 5'd0, s_last_addr}, {8'd1, 5'd0, 3'd5});
        chk("proto_rdy", {8'(r0_cnt - rb0), 8'(r1_cnt - rb1)}, {8'd0, 8'd1});
        chk("proto_rdata", M1_IO_Read_Data, 32'hA5A5_0005);
        chk("proto_idle", arb_busy, 1'b0);

`ifdef MB_IO_ARB_TIMEOUT_EN
        // ---- timeout: silent slave on an M1 read, M0 queued behind it
        slave_en = 0;
        rb0 = r0_cnt;
        m_req(1, 1, 3'd7, 32'h0, 4'hF);           // N
        step(); clr_m(); n = 1;
        m_req(0, 1, 3'd1, 32'h0, 4'hF);           // N+1
        step(); clr_m(); n = 2;
        while (!M1_IO_Ready && n < 60) begin
            step();
            n++;
        end
        chk("tmo_latency", 128'(n), 128'd20);
        chk("tmo_pulse", {M1_IO_Ready, arb_timeout, M0_IO_Ready}, 3'b110);
        chk("tmo_rdata", M1_IO_Read_Data, 32'hDEAD_BEEF);
        late_rdy = 1; slave_en = 1;
        step();                                    // N+21: late Ready during ISSUE
        late_rdy = 0;
        chk("tmo_m0_issue", {S_IO_Read_Strobe, arb_grant, S_IO_Address}, {1'b1, 1'b0, 3'd1});
        chk("tmo_no_repeat", {M1_IO_Ready, arb_timeout}, 2'b00);
        step(); step();                            // N+23
        chk("tmo_m0_rdy", {M0_IO_Ready, arb_timeout}, 2'b10);
        chk("tmo_m0_data", M0_IO_Read_Data, 32'h1234_5678);
        step(); step();
        chk("tmo_m0_once", 128'(r0_cnt - rb0), 128'd1);
`else
        // ---- no watchdog: a silent slave leaves the arbiter busy
        slave_en = 0;
        rb1 = r1_cnt;
        m_req(1, 1, 3'd7, 32'h0, 4'hF);
        step(); clr_m();
        for (int i = 0; i < 40; i++) step();
        chk("stuck_busy", {arb_busy, arb_timeout}, 2'b10);
        chk("stuck_no_rdy", 128'(r1_cnt - rb1), 128'd0);
        slave_en = 1;
        do_reset();
`endif

        // ---- reset during WAIT, M1 request pending gets lost
        slave_en = 0;
        m_req(0, 1, 3'd2, 32'h0, 4'hF);           // N
        step(); clr_m();
        m_req(1, 1, 3'd3, 32'h0, 4'hF);           // N+1
        step(); clr_m();
        step(); step();                            // N+4 in WAIT
        chk("rw_busy", arb_busy, 1'b1);
        #2 reset_n = 0;
        #1 chk("rw_async_zero", 128'(all_out), 128'd0);
        step(); step();
        reset_n = 1;
        slave_en = 1;
        sb = s_cnt; rb0 = r0_cnt; rb1 = r1_cnt;
        m_req(0, 1, 3'd1, 32'h0, 4'hF);
        step(); clr_m();
        step();
        chk("rw_issue", {S_IO_Read_Strobe, arb_grant, S_IO_Address}, {1'b1, 1'b0, 3'd1});
        step(); step();
        chk("rw_m0_rdy", {M0_IO_Ready, M1_IO_Ready}, 2'b10);
        chk("rw_m0_data", M0_IO_Read_Data, 32'h1234_5678);
        for (int i = 0; i < 6; i++) step();
        chk("rw_lost_pend", {8'(s_cnt - sb), 8'(r1_cnt - rb1), 8'(r0_cnt - rb0)}, {8'd1, 8'd0, 8'd1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
